cpu_run_control: RTL and testbench
==================================

Name: cpu_run_control

Overview:
Parametrised run controller between the top-level clock/reset and the MiniSRC core. It stretches the external clear into a programmable-length CPU clear. It then provides run, single-step and pause control through a clock enable, and counts executed cycles. It detects the CPU halt state and aborts runaway programs with a watchdog, so benches and board top levels drive the core through one block.

Parameters:
RST_CYCLES, 2, number of cycles cpu_clr stays high after clr falls (must be >=1)
STATE_W, 8, width of the CPU present_state bus
HALT_STATE, 8'hFF, present_state encoding that marks the CPU halted
CNT_W, 32, width of cycle_count
TIMEOUT, 0, watchdog limit in enabled cycles; 0 disables the watchdog

Ports:
clk  input  1  system clock, rising edge
clr  input  1  synchronous active-high reset
run_req  input  1  start/resume free run (level, sampled in IDLE)
step_req  input  1  execute exactly one enabled CPU cycle (sampled in IDLE)
halt_req  input  1  pause free run, return to IDLE
present_state  input  STATE_W  CPU control-unit state
cpu_clr  output  1  clear to CPU core
cpu_en  output  1  clock enable to CPU core
cycle_count  output  CNT_W  enabled cycles since last clr
run_state  output  3  controller state encoding
done  output  1  CPU reached HALT_STATE
timeout  output  1  watchdog fired

Behaviour:
- One clock: clk. clr is synchronous, active-high, and sampled only on the rising edge of clk. It overrides everything, including mid-run and mid-step.
- Outputs are Moore, decoded from registered state only. cycle_count, done and timeout are registers.
- States and run_state encodings: RESET=0, IDLE=1, RUN=2, STEP=3, HALTED=4, TIMEDOUT=5. Encodings 6 and 7 are illegal and go to RESET on the next edge.
- Edge with clr=1: state<=RESET, rst_cnt<=0, cycle_count<=0, done<=0, timeout<=0.
  - Outputs after that edge: cpu_clr=1, cpu_en=1, run_state=0.
- RESET: cpu_clr=1, cpu_en=1 (so the core's synchronous clear takes effect).
  - rst_cnt increments each edge with clr=0.
  - When rst_cnt==RST_CYCLES-1, go to IDLE. cpu_clr is therefore high for exactly RST_CYCLES cycles after the last clr edge.
- IDLE: cpu_clr=0, cpu_en=0.
  - run_req=1 -> RUN.
  - Else step_req=1 -> STEP.
  - run_req has priority when both are high. halt_req is ignored.
- RUN: cpu_en=1. cycle_count increments on every edge leaving or remaining in RUN, and saturates at all-ones (no wrap). Exit priority, highest first:
  1. present_state==HALT_STATE -> HALTED.
  2. TIMEOUT!=0 and cycle_count==TIMEOUT-1 -> TIMEDOUT.
  3. halt_req=1 -> IDLE.
  4. Otherwise stay in RUN.
- STEP: cpu_en=1 for exactly one cycle and cycle_count increments.
  - Next state is HALTED if present_state==HALT_STATE, else TIMEDOUT on the watchdog condition, else IDLE.
  - A held step_req re-steps on every IDLE visit, giving one enabled cycle per two clocks.
- HALTED: cpu_en=0, done=1. Stays until clr.
- TIMEDOUT: cpu_en=0, timeout=1. Stays until clr.
- Latency:
  - run_req high before edge N (in IDLE) gives cpu_en=1 in the cycle after edge N.
  - halt_req high in RUN before edge N gives cpu_en=0 after edge N. The CPU executes the cycle ending at edge N.
- cycle_count holds its value in IDLE, HALTED and TIMEDOUT. A resume continues counting from the held value.

Test Plan:
- Reset: clr=1 for 1 cycle, RST_CYCLES=2 -> cpu_clr=1 for exactly 2 cycles after clr falls, then run_state=1, cpu_en=0, cycle_count=0.
- Halt detect: run_req=1; drive present_state=8'hFF after 10 cycles in RUN -> run_state=4, done=1, cpu_en=0, cycle_count=11, held stable for 20 further cycles.
- Pause/resume: in RUN, halt_req=1 after 5 enabled cycles -> IDLE, cycle_count=5; run_req=1 again for 3 cycles then halt_req -> cycle_count=8.
- Single step: in IDLE pulse step_req 3 times, spaced apart -> exactly 3 one-cycle cpu_en pulses, cycle_count=3, run_state back to 1 each time.
- Watchdog: TIMEOUT=16, run with present_state never 8'hFF -> after 16 enabled cycles run_state=5, timeout=1, cpu_en=0. Same stimulus with present_state=8'hFF at count 15 -> HALTED wins, timeout=0.
- Reset mid-run and saturation: clr=1 during RUN -> RESET next edge, counters cleared. With CNT_W=4 and TIMEOUT=0, 20 RUN cycles -> cycle_count=4'hF, no wrap.

Source files
------------

// File: rtl/cpu_run_control.sv
// Run controller for the MiniSRC core: stretched CPU clear, run/step/pause via a
// clock enable, enabled-cycle counter, halt detection and an optional watchdog.
module cpu_run_control #(
   parameter int                 RST_CYCLES = 2,
   parameter int                 STATE_W    = 8,
   parameter logic [STATE_W-1:0] HALT_STATE = 8'hFF,
   parameter int                 CNT_W      = 32,
   parameter int                 TIMEOUT    = 0
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               run_req,
   input  logic               step_req,
   input  logic               halt_req,
   input  logic [STATE_W-1:0] present_state,
   output logic               cpu_clr,
   output logic               cpu_en,
   output logic [CNT_W-1:0]   cycle_count,
   output logic [2:0]         run_state,
   output logic               done,
   output logic               timeout
);

   typedef enum logic [2:0] {
      S_RESET    = 3'd0,
      S_IDLE     = 3'd1,
      S_RUN      = 3'd2,
      S_STEP     = 3'd3,
      S_HALTED   = 3'd4,
      S_TIMEDOUT = 3'd5
   } state_t;

   localparam int                 RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0]      RST_LAST = RW'(RST_CYCLES - 1);
   localparam bit                 WD_ON    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0]   WD_LAST  = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [RW-1:0]    rst_cnt;
   logic [CNT_W-1:0] count_next;
   logic             at_halt;
   logic             wd_hit;

   // Counter saturates at all-ones so a long free run never looks like a fresh start.
   assign count_next = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
   assign at_halt    = (present_state == HALT_STATE);
   assign wd_hit     = WD_ON && (cycle_count == WD_LAST);

   always_ff @(posedge clk) begin
      if (clr) begin
         state       <= S_RESET;
         rst_cnt     <= '0;
         cycle_count <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         case (state)
            S_RESET: begin
               if (rst_cnt == RST_LAST) state <= S_IDLE;
               else                     rst_cnt <= rst_cnt + RW'(1);
            end
            S_IDLE: begin
               if (run_req)       state <= S_RUN;
               else if (step_req) state <= S_STEP;
            end
            S_RUN: begin
               cycle_count <= count_next;
               if (at_halt) begin
                  state <= S_HALTED;
                  done  <= 1'b1;
               end else if (wd_hit) begin
                  state   <= S_TIMEDOUT;
                  timeout <= 1'b1;
               end else if (halt_req) begin
                  state <= S_IDLE;
               end
            end
            S_STEP: begin
               cycle_count <= count_next;
               if (at_halt) begin
                  state <= S_HALTED;
                  done  <= 1'b1;
               end else if (wd_hit) begin
                  state   <= S_TIMEDOUT;
                  timeout <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_HALTED, S_TIMEDOUT: begin
               state <= state;
            end
            default: begin
               state   <= S_RESET;
               rst_cnt <= '0;
            end
         endcase
      end
   end

   // The core clears synchronously, so it must be enabled while cpu_clr is high.
   assign cpu_clr   = (state == S_RESET);
   assign cpu_en    = (state == S_RESET) || (state == S_RUN) || (state == S_STEP);
   assign run_state = state;

endmodule

// File: tb/tb_cpu_run_control.sv
// Directed bench for cpu_run_control: expectations are queued with the cycle they
// apply to, and a negedge monitor pops and compares them against the outputs.
module tb_cpu_run_control;

   localparam logic [3:0] SIG_CLR  = 4'd0;
   localparam logic [3:0] SIG_EN   = 4'd1;
   localparam logic [3:0] SIG_CNT  = 4'd2;
   localparam logic [3:0] SIG_RS   = 4'd3;
   localparam logic [3:0] SIG_DONE = 4'd4;
   localparam logic [3:0] SIG_TO   = 4'd5;
   localparam logic [3:0] SIG_SCNT = 4'd6;
   localparam logic [3:0] SIG_SRS  = 4'd7;

   typedef struct packed {
      logic [31:0] cyc;
      logic [3:0]  sel;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr;
   logic        run_req;
   logic        step_req;
   logic        halt_req;
   logic [7:0]  present_state;
   logic        cpu_clr;
   logic        cpu_en;
   logic [31:0] cycle_count;
   logic [2:0]  run_state;
   logic        done;
   logic        timeout;
   logic        s_cpu_clr;
   logic        s_cpu_en;
   logic [3:0]  s_cycle_count;
   logic [2:0]  s_run_state;
   logic        s_done;
   logic        s_timeout;

   logic [31:0] cyc = 32'd0;
   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_pass = 0;
   int          n_total = 0;

   // Clock and cycle index
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   cpu_run_control #(.RST_CYCLES(2), .STATE_W(8), .HALT_STATE(8'hFF), .CNT_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .clr(clr), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .present_state(present_state), .cpu_clr(cpu_clr), .cpu_en(cpu_en),
      .cycle_count(cycle_count), .run_state(run_state), .done(done), .timeout(timeout)
   );

   cpu_run_control #(.RST_CYCLES(2), .STATE_W(8), .HALT_STATE(8'hFF), .CNT_W(4), .TIMEOUT(0)) dut_sat (
      .clk(clk), .clr(clr), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .present_state(present_state), .cpu_clr(s_cpu_clr), .cpu_en(s_cpu_en),
      .cycle_count(s_cycle_count), .run_state(s_run_state), .done(s_done), .timeout(s_timeout)
   );

   function automatic logic [31:0] actual(input logic [3:0] sel);
      case (sel)
         SIG_CLR:  return {31'b0, cpu_clr};
         SIG_EN:   return {31'b0, cpu_en};
         SIG_CNT:  return cycle_count;
         SIG_RS:   return {29'b0, run_state};
         SIG_DONE: return {31'b0, done};
         SIG_TO:   return {31'b0, timeout};
         SIG_SCNT: return {28'b0, s_cycle_count};
         SIG_SRS:  return {29'b0, s_run_state};
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic string sig_name(input logic [3:0] sel);
      case (sel)
         SIG_CLR:  return "cpu_clr";
         SIG_EN:   return "cpu_en";
         SIG_CNT:  return "cycle_count";
         SIG_RS:   return "run_state";
         SIG_DONE: return "done";
         SIG_TO:   return "timeout";
         SIG_SCNT: return "sat_cycle_count";
         SIG_SRS:  return "sat_run_state";
         default:  return "unknown";
      endcase
   endfunction

   // Monitor: compare every expectation due in this cycle, away from the active edge
   always @(negedge clk) begin
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         n_total++;
         if (mon_e.cyc != cyc)
            $display("FAIL %s stale (due cycle %0d, now %0d)", sig_name(mon_e.sel), mon_e.cyc, cyc);
         else if (actual(mon_e.sel) === mon_e.val)
            n_pass++;
         else
            $display("FAIL %s at cycle %0d: got %0h, expected %0h",
                     sig_name(mon_e.sel), cyc, actual(mon_e.sel), mon_e.val);
      end
   end

   // Driver tasks
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_sig(input logic [3:0] sel, input logic [31:0] val);
      exp_t e;
      e.cyc = cyc;
      e.sel = sel;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic chk(input int rs, input int cnt, input int en, input int dn, input int to);
      expect_sig(SIG_RS, 32'(rs));
      expect_sig(SIG_CNT, 32'(cnt));
      expect_sig(SIG_EN, 32'(en));
      expect_sig(SIG_DONE, 32'(dn));
      expect_sig(SIG_TO, 32'(to));
   endtask

   task automatic do_reset();
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      step(2);
   endtask

   task automatic start_run();
      run_req = 1'b1;
      step(1);
      run_req = 1'b0;
   endtask

   initial begin
      clr = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; present_state = 8'h00;

      // Reset: two cycles of cpu_clr after clr falls, then IDLE
      step(1);
      expect_sig(SIG_CLR, 32'd1);
      chk(0, 0, 1, 0, 0);
      clr = 1'b0;
      step(1);
      expect_sig(SIG_CLR, 32'd1);
      expect_sig(SIG_RS, 32'd0);
      step(1);
      expect_sig(SIG_CLR, 32'd0);
      chk(1, 0, 0, 0, 0);

      // Halt detect after 10 RUN cycles, then held
      start_run();
      chk(2, 0, 1, 0, 0);
      step(10);
      chk(2, 10, 1, 0, 0);
      present_state = 8'hFF;
      step(1);
      chk(4, 11, 0, 1, 0);
      present_state = 8'h00;
      step(20);
      chk(4, 11, 0, 1, 0);

      // Pause after 5 enabled cycles, resume for 3 more
      do_reset();
      start_run();
      step(4);
      chk(2, 4, 1, 0, 0);
      halt_req = 1'b1;
      step(1);
      halt_req = 1'b0;
      chk(1, 5, 0, 0, 0);
      step(2);
      chk(1, 5, 0, 0, 0);
      run_req = 1'b1;
      step(1);
      chk(2, 5, 1, 0, 0);
      step(2);
      run_req = 1'b0;
      chk(2, 7, 1, 0, 0);
      halt_req = 1'b1;
      step(1);
      halt_req = 1'b0;
      chk(1, 8, 0, 0, 0);

      // run_req beats step_req; halt_req ignored in IDLE
      halt_req = 1'b1;
      step(1);
      chk(1, 8, 0, 0, 0);
      halt_req = 1'b0;
      run_req = 1'b1; step_req = 1'b1;
      step(1);
      run_req = 1'b0; step_req = 1'b0;
      chk(2, 8, 1, 0, 0);
      step(1);
      chk(2, 9, 1, 0, 0);
      halt_req = 1'b1;
      step(1);
      halt_req = 1'b0;
      chk(1, 10, 0, 0, 0);

      // Single step: three spaced pulses
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step_req = 1'b1;
         step(1);
         step_req = 1'b0;
         chk(3, i, 1, 0, 0);
         step(1);
         chk(1, i + 1, 0, 0, 0);
         step(2);
         chk(1, i + 1, 0, 0, 0);
      end
      // Held step_req: one enabled cycle per two clocks
      step_req = 1'b1;
      step(1);
      chk(3, 3, 1, 0, 0);
      step(1);
      chk(1, 4, 0, 0, 0);
      step(1);
      step_req = 1'b0;
      chk(3, 4, 1, 0, 0);
      step(1);
      chk(1, 5, 0, 0, 0);

      // Watchdog fires after 16 enabled cycles
      do_reset();
      start_run();
      step(15);
      chk(2, 15, 1, 0, 0);
      step(1);
      chk(5, 16, 0, 0, 1);
      step(3);
      chk(5, 16, 0, 0, 1);

      // Halt on the watchdog cycle wins
      do_reset();
      start_run();
      step(15);
      present_state = 8'hFF;
      step(1);
      present_state = 8'h00;
      chk(4, 16, 0, 1, 0);

      // Saturation on the 4-bit instance
      do_reset();
      start_run();
      expect_sig(SIG_SRS, 32'd2);
      expect_sig(SIG_SCNT, 32'd0);
      step(14);
      expect_sig(SIG_SCNT, 32'd14);
      step(6);
      expect_sig(SIG_SRS, 32'd2);
      expect_sig(SIG_SCNT, 32'd15);
      chk(5, 16, 0, 0, 1);

      // clr mid-run clears everything on the next edge
      do_reset();
      start_run();
      step(3);
      chk(2, 3, 1, 0, 0);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      expect_sig(SIG_CLR, 32'd1);
      chk(0, 0, 1, 0, 0);
      expect_sig(SIG_SRS, 32'd0);
      expect_sig(SIG_SCNT, 32'd0);
      step(2);
      chk(1, 0, 0, 0, 0);

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
         n_total += exp_q.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
